// File: rtl/serial_adder.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : serial_adder
// Description : Multi-cycle two-operand adder. Adds a WIDTH-bit pair DIGIT bits
//               per clock, keeping the slice carry in a register. Results are
//               presented with a start/busy/done handshake together with
//               carry-out and signed overflow.
//               Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub port
//               and two's-complement subtraction).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4     // must divide WIDTH exactly
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int c_nslice = WIDTH / DIGIT;
   localparam int c_cw     = (c_nslice > 1) ? $clog2(c_nslice) : 1;
   localparam logic [c_cw-1:0] c_last    = c_cw'(c_nslice - 1);
   localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_wa;       // working A, consumed from the bottom
   logic [WIDTH-1:0] r_wb;       // working effective B, consumed from the bottom
   logic [WIDTH-1:0] r_ws;       // working sum, filled from the top
   logic             r_carry;
   logic [c_cw-1:0]  r_cnt;
   logic             r_a_msb;    // sign of A, kept because working A shifts away
   logic             r_b_msb;    // sign of effective B

   logic [WIDTH-1:0] w_beff;
   logic             w_c0;
   logic [DIGIT:0]   w_slice;
   logic [WIDTH-1:0] w_ws_next;
   logic             w_last;

   // Effective B operand and initial carry, chosen at capture time
`ifdef SERIAL_ADDER_SUB_EN
   assign w_beff = sub ? ~b : b;
   assign w_c0   = sub ? 1'b1 : cin;
`else
   assign w_beff = b;
   assign w_c0   = cin;
`endif

   // One DIGIT-wide slice of the addition, carry in from the carry register
   assign w_slice = {1'b0, r_wa[DIGIT-1:0]} + {1'b0, r_wb[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

   // The new partial sum enters at the top; after NSLICE shifts the word is aligned
   generate
      if (c_nslice == 1) begin : g_single
         assign w_ws_next = w_slice[DIGIT-1:0];
      end else begin : g_multi
         assign w_ws_next = {w_slice[DIGIT-1:0], r_ws[WIDTH-1:DIGIT]};
      end
   endgenerate

   assign w_last = (r_cnt == c_last);
   assign busy   = (r_state == S_RUN);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: accept start only while idle, leave RUN after the last slice
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: if (start)  w_state_next = S_RUN;
         S_RUN:  if (w_last) w_state_next = S_IDLE;
         default:            w_state_next = S_IDLE;
      endcase
   end

   // Datapath: operand capture, slice iteration and result load on completion
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wa    <= '0;
         r_wb    <= '0;
         r_ws    <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_a_msb <= 1'b0;
         r_b_msb <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_wa    <= a;
                  r_wb    <= w_beff;
                  r_carry <= w_c0;
                  r_cnt   <= '0;
                  r_a_msb <= a[WIDTH-1];
                  r_b_msb <= w_beff[WIDTH-1];
               end
            end
            S_RUN: begin
               r_wa    <= r_wa >> DIGIT;
               r_wb    <= r_wb >> DIGIT;
               r_ws    <= w_ws_next;
               r_carry <= w_slice[DIGIT];
               r_cnt   <= r_cnt + c_cnt_one;
               if (w_last) begin
                  sum  <= w_ws_next;
                  cout <= w_slice[DIGIT];
                  ovf  <= (r_a_msb == r_b_msb) && (w_ws_next[WIDTH-1] != r_a_msb);
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
